adder_tree_accum: RTL and testbench



---
 rtl/adder_tree_accum_pkg.sv | 29 ++
 rtl/adder_tree_accum_add_node.sv | 46 ++++
 rtl/adder_tree_accum.sv | 166 ++++++++++++++++
 tb/tb_adder_tree_accum.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_accum_pkg.sv
// Shared constants, tag type and helper functions for the pipelined adder tree
// and its row accumulator.
package adder_tree_accum_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_NUM_IN = 16;
    localparam int DEFAULT_CNT_W  = 16;

    // Per-beat control that travels down the tree beside the data.
    typedef struct packed {
        logic last;
        logic acc_en;
    } beat_tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Two's-complement add overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage

// File: rtl/adder_tree_accum_add_node.sv
// One registered node of the reduction tree: wrapping add, signed-overflow
// detection OR-ed with the children's flags, and a valid bit.
module add_node
    import adder_tree_accum_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              vld_in,
    input  logic              ovf_in,
    output logic [DATA_W-1:0] sum,
    output logic              vld_out,
    output logic              ovf_out
);

    logic [DATA_W-1:0] sum_d;
    logic [DATA_W-1:0] sum_q;
    logic              ovf_d;
    logic              ovf_q;
    logic              vld_q;

    always_comb begin
        sum_d = a + b;
        ovf_d = ovf_in | add_ovf(a[DATA_W-1], b[DATA_W-1], sum_d[DATA_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
            vld_q <= vld_in;
        end
    end

    assign sum     = sum_q;
    assign vld_out = vld_q;
    assign ovf_out = ovf_q;

endmodule

// File: rtl/adder_tree_accum.sv
// Fully pipelined NUM_IN-operand signed reduction tree followed by a one-cycle
// row accumulator that emits either per-beat sums or multi-beat row totals.
module adder_tree_accum
    import adder_tree_accum_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic                     acc_en,
    input  logic [NUM_IN*DATA_W-1:0] din,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_sum,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_ovf
);

    localparam int LVL   = clog2(NUM_IN);
    localparam int NODES = 2*NUM_IN - 1;
    localparam int ROOT  = NODES - 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
        $error("adder_tree_accum: NUM_IN must be a power of two >= 2");
    end

    // Flat node storage: leaves at 0..NUM_IN-1, then each level packed after
    // the previous one, so level k starts at 2*NUM_IN - 2*(NUM_IN >> k).
    logic [DATA_W-1:0] node_sum [NODES];
    logic              node_vld [NODES];
    logic              node_ovf [NODES];

    genvar gi;
    genvar gj;

    for (gi = 0; gi < NUM_IN; gi++) begin : g_leaf
        assign node_sum[gi] = din[gi*DATA_W +: DATA_W];
        assign node_vld[gi] = in_valid;
        assign node_ovf[gi] = 1'b0;
    end

    for (gi = 1; gi <= LVL; gi++) begin : g_lvl
        localparam int IN_BASE  = 2*NUM_IN - 2*(NUM_IN >> (gi - 1));
        localparam int OUT_BASE = 2*NUM_IN - 2*(NUM_IN >> gi);
        for (gj = 0; gj < (NUM_IN >> gi); gj++) begin : g_node
            add_node #(
                .DATA_W (DATA_W)
            ) u_node (
                .clk     (clk),
                .rst     (rst),
                .a       (node_sum[IN_BASE + 2*gj]),
                .b       (node_sum[IN_BASE + 2*gj + 1]),
                .vld_in  (node_vld[IN_BASE + 2*gj] & node_vld[IN_BASE + 2*gj + 1]),
                .ovf_in  (node_ovf[IN_BASE + 2*gj] | node_ovf[IN_BASE + 2*gj + 1]),
                .sum     (node_sum[OUT_BASE + gj]),
                .vld_out (node_vld[OUT_BASE + gj]),
                .ovf_out (node_ovf[OUT_BASE + gj])
            );
        end
    end

    beat_tag_t tag_q [LVL];

    for (gi = 0; gi < LVL; gi++) begin : g_tag
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_q[gi] <= '0;
            end else if (gi == 0) begin
                tag_q[gi] <= '{last: in_last, acc_en: acc_en};
            end else begin
                tag_q[gi] <= tag_q[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    logic [DATA_W-1:0] root_sum;
    logic              root_vld;
    logic              root_ovf;
    beat_tag_t         root_tag;

    assign root_sum = node_sum[ROOT];
    assign root_vld = node_vld[ROOT];
    assign root_ovf = node_ovf[ROOT];
    assign root_tag = tag_q[LVL-1];

    logic [DATA_W-1:0] acc_d, acc_q;
    logic [CNT_W-1:0]  row_cnt_d, row_cnt_q;
    logic              row_ovf_d, row_ovf_q;
    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] out_sum_d, out_sum_q;
    logic [CNT_W-1:0]  out_count_d, out_count_q;
    logic              out_ovf_d, out_ovf_q;

    logic [DATA_W-1:0] row_total;
    logic [CNT_W-1:0]  row_cnt_inc;
    logic              row_ovf_total;

    always_comb begin
        row_total     = acc_q + root_sum;
        row_cnt_inc   = (row_cnt_q == CNT_MAX) ? CNT_MAX : row_cnt_q + CNT_ONE;
        row_ovf_total = row_ovf_q | root_ovf
                      | add_ovf(acc_q[DATA_W-1], root_sum[DATA_W-1], row_total[DATA_W-1]);

        acc_d       = acc_q;
        row_cnt_d   = row_cnt_q;
        row_ovf_d   = row_ovf_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (root_vld) begin
            if (!root_tag.acc_en) begin
                // Stand-alone beat: the open row is left exactly as it was.
                out_valid_d = 1'b1;
                out_sum_d   = root_sum;
                out_count_d = CNT_ONE;
                out_ovf_d   = root_ovf;
            end else if (!root_tag.last) begin
                acc_d     = row_total;
                row_cnt_d = row_cnt_inc;
                row_ovf_d = row_ovf_total;
            end else begin
                out_valid_d = 1'b1;
                out_sum_d   = row_total;
                out_count_d = row_cnt_inc;
                out_ovf_d   = row_ovf_total;
                acc_d       = '0;
                row_cnt_d   = '0;
                row_ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            row_cnt_q   <= '0;
            row_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            row_cnt_q   <= row_cnt_d;
            row_ovf_q   <= row_ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed bench for adder_tree_accum (16 x 64-bit operands, 4-bit beat counter
// so that count saturation is reachable).
module tb_adder_tree_accum;

    localparam int DW = 64;
    localparam int NI = 16;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_last;
    logic           acc_en;
    logic [NI*DW-1:0] din;
    logic           out_valid;
    logic [DW-1:0]  out_sum;
    logic [CW-1:0]  out_count;
    logic           out_ovf;

    adder_tree_accum #(
        .DATA_W (DW),
        .NUM_IN (NI),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .acc_en    (acc_en),
        .din       (din),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] obs_sum [$];
    logic [CW-1:0] obs_cnt [$];
    logic          obs_ovf [$];
    int            obs_cyc [$];
    logic [DW-1:0] exp_sum [$];
    logic [CW-1:0] exp_cnt [$];
    logic          exp_ovf [$];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_sum.push_back(out_sum);
            obs_cnt.push_back(out_count);
            obs_ovf.push_back(out_ovf);
            obs_cyc.push_back(cyc);
            $display("[%0d] out: sum=0x%0h count=%0d ovf=%0b", cyc, out_sum, out_count, out_ovf);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [NI*DW-1:0] pack_two(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
        logic [NI*DW-1:0] r;
        r = '0;
        r[0 +: DW]  = v0;
        r[DW +: DW] = v1;
        return r;
    endfunction

    function automatic logic [NI*DW-1:0] pack_fill(input logic [DW-1:0] v);
        logic [NI*DW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [NI*DW-1:0] pack_ramp();
        logic [NI*DW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*DW +: DW] = DW'(i + 1);
        return r;
    endfunction

    function automatic logic [NI*DW-1:0] pack_alt();
        logic [NI*DW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*DW +: DW] = (i % 2 == 0) ? -64'sd3 : 64'sd1;
        return r;
    endfunction

    task automatic drive(input logic [NI*DW-1:0] d, input logic last, input logic en);
        @(negedge clk);
        in_valid = 1'b1;
        din      = d;
        in_last  = last;
        acc_en   = en;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            acc_en   = 1'b0;
            din      = '0;
        end
    endtask

    task automatic expect_out(input logic [DW-1:0] s, input logic [CW-1:0] c, input logic o);
        exp_sum.push_back(s);
        exp_cnt.push_back(c);
        exp_ovf.push_back(o);
    endtask

    task automatic drain(input string tag);
        int n;
        idle(10);
        check_val({tag, " n_out"}, 64'(obs_sum.size()), 64'(exp_sum.size()));
        n = (obs_sum.size() < exp_sum.size()) ? obs_sum.size() : exp_sum.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s[%0d] sum", tag, i), obs_sum[i], exp_sum[i]);
            check_val($sformatf("%s[%0d] count", tag, i), 64'(obs_cnt[i]), 64'(exp_cnt[i]));
            check_val($sformatf("%s[%0d] ovf", tag, i), 64'(obs_ovf[i]), 64'(exp_ovf[i]));
        end
        obs_sum.delete(); obs_cnt.delete(); obs_ovf.delete(); obs_cyc.delete();
        exp_sum.delete(); exp_cnt.delete(); exp_ovf.delete();
    endtask

    initial begin
        int drv_cyc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_en   = 1'b0;
        din      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset out_valid", 64'(out_valid), 64'd0);
        check_val("reset out_sum",   out_sum,         64'd0);
        check_val("reset out_count", 64'(out_count), 64'd0);
        check_val("reset out_ovf",   64'(out_ovf),   64'd0);

        // Per-beat mode, latency and hold between pulses.
        drive(pack_fill(64'd1), 1'b0, 1'b0);
        drv_cyc = cyc;
        idle(8);
        check_val("t1 latency", (obs_cyc.size() > 0) ? 64'(obs_cyc[0] - drv_cyc) : 64'hFFFF, 64'd5);
        expect_out(64'd16, 4'd1, 1'b0);
        drain("t1");
        check_val("t1 hold sum", out_sum, 64'd16);
        check_val("t1 hold valid", 64'(out_valid), 64'd0);

        // Three-beat row with a bubble inside it.
        drive(pack_ramp(), 1'b0, 1'b1);
        idle(2);
        drive(pack_ramp(), 1'b0, 1'b1);
        drive(pack_ramp(), 1'b1, 1'b1);
        expect_out(64'd408, 4'd3, 1'b0);
        drain("t2");

        // Signed negative per-beat sum.
        drive(pack_alt(), 1'b0, 1'b0);
        expect_out(64'hFFFF_FFFF_FFFF_FFF0, 4'd1, 1'b0);
        drain("t_neg");

        // Tree overflow, then a clean zero row.
        drive(pack_two(64'h7FFF_FFFF_FFFF_FFFF, 64'd1), 1'b1, 1'b1);
        drive(pack_fill(64'd0), 1'b1, 1'b1);
        expect_out(64'h8000_0000_0000_0000, 4'd1, 1'b1);
        expect_out(64'd0, 4'd1, 1'b0);
        drain("t3");

        // Overflow in the accumulator, then a clean row.
        drive(pack_two(64'h4000_0000_0000_0000, 64'd0), 1'b0, 1'b1);
        drive(pack_two(64'h4000_0000_0000_0000, 64'd0), 1'b1, 1'b1);
        drive(pack_two(64'd3, 64'd4), 1'b1, 1'b1);
        expect_out(64'h8000_0000_0000_0000, 4'd2, 1'b1);
        expect_out(64'd7, 4'd1, 1'b0);
        drain("t_accovf");

        // Back-to-back single-beat rows.
        for (int k = 1; k <= 8; k++) begin
            drive(pack_two(64'(k), 64'd0), 1'b1, 1'b1);
            expect_out(64'(k), 4'd1, 1'b0);
        end
        idle(10);
        for (int k = 1; k < 8; k++) begin
            check_val($sformatf("t4 spacing %0d", k),
                      (obs_cyc.size() > k) ? 64'(obs_cyc[k] - obs_cyc[0]) : 64'hFFFF, 64'(k));
        end
        drain("t4");

        // Reset with a row open and a closing beat still inside the tree.
        drive(pack_two(64'd100, 64'd0), 1'b0, 1'b1);
        drive(pack_two(64'd100, 64'd0), 1'b0, 1'b1);
        idle(6);
        drive(pack_two(64'd50, 64'd0), 1'b1, 1'b1);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_val("t5 post-reset sum",   out_sum,         64'd0);
        check_val("t5 post-reset count", 64'(out_count), 64'd0);
        drive(pack_two(64'd2, 64'd3), 1'b1, 1'b1);
        expect_out(64'd5, 4'd1, 1'b0);
        drain("t5");

        // Count saturation with an interleaved stand-alone beat (in_last ignored).
        for (int b = 1; b <= 20; b++) begin
            drive(pack_two(64'd1, 64'd0), (b == 20), 1'b1);
            if (b == 10) drive(pack_two(64'd7, 64'd0), 1'b1, 1'b0);
        end
        expect_out(64'd7, 4'd1, 1'b0);
        expect_out(64'd20, 4'd15, 1'b0);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
